// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU function codes and the ID/EX payload layout for the
// ID/EX pipeline register and its forwarding logic.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned FUN_W   = 6;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [RADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [FUN_W-1:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101,
    ALU_LEZ = 6'b111101,
    ALU_GEZ = 6'b111001,
    ALU_GTZ = 6'b111111
  } alufun_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   imm;
    logic [SHAMT_W-1:0]  shamt;
    logic [RADDR_W-1:0]  rs_addr;
    logic [RADDR_W-1:0]  rt_addr;
    logic [RADDR_W-1:0]  rd;
    logic                alusrc1;
    logic                alusrc2;
    logic [FUN_W-1:0]    alufun;
    logic                sign;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } id_ex_t;

  // A writeback stage supplies addr when it writes a matching, non-zero register.
  function automatic logic wb_hits(input logic we, input logic [RADDR_W-1:0] rd,
                                   input logic [RADDR_W-1:0] addr);
    return we && (rd != ZERO_REG) && (rd == addr);
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand bypass for one source register: EX/MEM beats MEM/WB beats the
// register-file value latched in ID/EX.
module id_ex_stage_forward_unit
  import id_ex_stage_pkg::*;
(
  input  logic [RADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0]  i_reg_data,
  input  logic               i_exmem_reg_write,
  input  logic [RADDR_W-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0]  i_exmem_result,
  input  logic               i_memwb_reg_write,
  input  logic [RADDR_W-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0]  i_memwb_result,
  output logic [DATA_W-1:0]  o_data
);

  fwd_sel_e w_sel;

  always_comb begin
    w_sel = FWD_REG;
    if (wb_hits(i_exmem_reg_write, i_exmem_rd, i_addr))
      w_sel = FWD_EXMEM;
    else if (wb_hits(i_memwb_reg_write, i_memwb_rd, i_addr))
      w_sel = FWD_MEMWB;
  end

  always_comb begin
    o_data = i_reg_data;
    case (w_sel)
      FWD_EXMEM: o_data = i_exmem_result;
      FWD_MEMWB: o_data = i_memwb_result;
      default:   o_data = i_reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded fields, forwards
// operands, detects load-use hazards and inserts bubbles on stall or flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [SHAMT_W-1:0] id_shamt,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_alusrc1,
  input  logic               id_alusrc2,
  input  logic [FUN_W-1:0]   id_alufun,
  input  logic               id_sign,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  input  logic               hold,
  input  logic               flush,
  output logic               stall_id,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_A,
  output logic [DATA_W-1:0]  ex_B,
  output logic [FUN_W-1:0]   ex_alufun,
  output logic               ex_sign,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write
);

  id_ex_t            r_ex;
  logic              r_flush_pend;
  id_ex_t            w_load;
  logic              w_bubble;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Load-use: the load in EX has no data until MEM, so ID must wait one cycle.
  always_comb begin
    stall_id = id_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != ZERO_REG) &&
               ((r_ex.rd == id_rs_addr) || (r_ex.rd == id_rt_addr)) &&
               !flush && !r_flush_pend;
  end

  assign w_bubble = flush || r_flush_pend || stall_id;

  // Controls are qualified by id_valid so an empty slot never writes.
  always_comb begin
    w_load           = '0;
    w_load.valid     = id_valid;
    w_load.pc        = id_pc;
    w_load.rs_data   = id_rs_data;
    w_load.rt_data   = id_rt_data;
    w_load.imm       = id_imm;
    w_load.shamt     = id_shamt;
    w_load.rs_addr   = id_rs_addr;
    w_load.rt_addr   = id_rt_addr;
    w_load.rd        = id_rd_addr;
    w_load.alusrc1   = id_alusrc1;
    w_load.alusrc2   = id_alusrc2;
    w_load.alufun    = id_alufun;
    w_load.sign      = id_sign;
    w_load.reg_write = id_reg_write && id_valid;
    w_load.mem_read  = id_mem_read && id_valid;
    w_load.mem_write = id_mem_write && id_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex         <= '0;
      r_flush_pend <= 1'b0;
    end else if (hold) begin
      r_flush_pend <= r_flush_pend | flush;
    end else if (w_bubble) begin
      r_ex         <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_ex         <= w_load;
      r_flush_pend <= 1'b0;
    end
  end

  id_ex_stage_forward_unit u_fwd_rs (
    .i_addr            (r_ex.rs_addr),
    .i_reg_data        (r_ex.rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_rs)
  );

  id_ex_stage_forward_unit u_fwd_rt (
    .i_addr            (r_ex.rt_addr),
    .i_reg_data        (r_ex.rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_rt)
  );

  assign ex_valid      = r_ex.valid;
  assign ex_pc         = r_ex.pc;
  assign ex_A          = r_ex.alusrc1 ? DATA_W'(r_ex.shamt) : w_fwd_rs;
  assign ex_B          = r_ex.alusrc2 ? r_ex.imm : w_fwd_rt;
  assign ex_alufun     = r_ex.alufun;
  assign ex_sign       = r_ex.sign;
  assign ex_store_data = w_fwd_rt;
  assign ex_rd         = r_ex.rd;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/forwarding scenarios plus
// a randomized stream, checked against a rule-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        reset;
    logic        id_valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        alusrc1;
    logic        alusrc2;
    logic [5:0]  alufun;
    logic        sign;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        exmem_rw;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_res;
    logic        memwb_rw;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_res;
    logic        hold;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  alufun;
    logic        sign;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, id_valid, id_alusrc1, id_alusrc2, id_sign;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs_addr, id_rt_addr, id_rd_addr;
  logic [5:0]  id_alufun;
  logic        exmem_reg_write, memwb_reg_write, hold, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall_id, ex_valid, ex_sign, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_pc, ex_A, ex_B, ex_store_data;
  logic [5:0]  ex_alufun;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  in_t  a;
  in_t  m_ex;
  logic m_valid = 1'b0;
  logic m_pend  = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rd_addr(id_rd_addr), .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
    .id_alufun(id_alufun), .id_sign(id_sign), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .hold(hold), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_A(ex_A), .ex_B(ex_B), .ex_alufun(ex_alufun),
    .ex_sign(ex_sign), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Value a source register holds as seen by EX in the current cycle.
  function automatic logic [31:0] operand(input logic [4:0] addr, input logic [31:0] regval);
    if (addr == 5'd0) return regval;
    if (a.exmem_rw && a.exmem_rd == addr) return a.exmem_res;
    if (a.memwb_rw && a.memwb_rd == addr) return a.memwb_res;
    return regval;
  endfunction

  function automatic logic model_stall();
    return a.id_valid && m_valid && m_ex.mem_read && m_ex.rd != 5'd0 &&
           (m_ex.rd == a.rs || m_ex.rd == a.rt) && !a.flush && !m_pend;
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.stall  = model_stall();
    e.valid  = m_valid;
    e.pc     = m_ex.pc;
    e.a      = m_ex.alusrc1 ? {27'd0, m_ex.shamt} : operand(m_ex.rs, m_ex.rs_data);
    e.b      = m_ex.alusrc2 ? m_ex.imm : operand(m_ex.rt, m_ex.rt_data);
    e.alufun = m_ex.alufun;
    e.sign   = m_ex.sign;
    e.store  = operand(m_ex.rt, m_ex.rt_data);
    e.rd     = m_ex.rd;
    e.rw     = m_valid & m_ex.reg_write;
    e.mr     = m_valid & m_ex.mem_read;
    e.mw     = m_valid & m_ex.mem_write;
    return e;
  endfunction

  // What the EX slot holds after a clock edge, given the inputs that were applied before it.
  task automatic model_edge();
    logic st;
    st = model_stall();
    if (a.reset) begin
      m_ex = '0; m_valid = 1'b0; m_pend = 1'b0;
    end else if (a.hold) begin
      m_pend = m_pend | a.flush;
    end else if (a.flush || m_pend || st) begin
      m_ex = '0; m_valid = 1'b0; m_pend = 1'b0;
    end else begin
      m_ex = a; m_valid = a.id_valid;
    end
  endtask

  task automatic apply(input in_t x);
    a = x;
    reset = x.reset; id_valid = x.id_valid; id_pc = x.pc;
    id_rs_data = x.rs_data; id_rt_data = x.rt_data; id_imm = x.imm;
    id_shamt = x.shamt; id_rs_addr = x.rs; id_rt_addr = x.rt; id_rd_addr = x.rd;
    id_alusrc1 = x.alusrc1; id_alusrc2 = x.alusrc2; id_alufun = x.alufun;
    id_sign = x.sign; id_reg_write = x.reg_write; id_mem_read = x.mem_read;
    id_mem_write = x.mem_write; exmem_reg_write = x.exmem_rw; exmem_rd = x.exmem_rd;
    exmem_result = x.exmem_res; memwb_reg_write = x.memwb_rw; memwb_rd = x.memwb_rd;
    memwb_result = x.memwb_res; hold = x.hold; flush = x.flush;
    sb.push_back(expected());
  endtask

  task automatic step(input in_t x);
    @(posedge clk);
    model_edge();
    #1;
    apply(x);
  endtask

  function automatic in_t rand_in();
    in_t x;
    x.reset     = ($urandom_range(0, 49) == 0);
    x.id_valid  = ($urandom_range(0, 3) != 0);
    x.pc        = $urandom;
    x.rs_data   = $urandom;
    x.rt_data   = $urandom;
    x.imm       = $urandom;
    x.shamt     = 5'($urandom);
    x.rs        = 5'($urandom_range(0, 7));
    x.rt        = 5'($urandom_range(0, 7));
    x.rd        = 5'($urandom_range(0, 7));
    x.alusrc1   = ($urandom_range(0, 3) == 0);
    x.alusrc2   = ($urandom_range(0, 2) == 0);
    x.alufun    = 6'($urandom);
    x.sign      = 1'($urandom);
    x.reg_write = 1'($urandom);
    x.mem_read  = ($urandom_range(0, 2) == 0);
    x.mem_write = ($urandom_range(0, 3) == 0);
    x.exmem_rw  = 1'($urandom);
    x.exmem_rd  = 5'($urandom_range(0, 7));
    x.exmem_res = $urandom;
    x.memwb_rw  = 1'($urandom);
    x.memwb_rd  = 5'($urandom_range(0, 7));
    x.memwb_res = $urandom;
    x.hold      = ($urandom_range(0, 7) == 0);
    x.flush     = ($urandom_range(0, 9) == 0);
    return x;
  endfunction

  // Monitor: every cycle the DUT presents one EX slot plus a stall decision.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("stall_id", 32'(stall_id), 32'(e.stall));
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_A", ex_A, e.a);
        chk("ex_B", ex_B, e.b);
        chk("ex_alufun", 32'(ex_alufun), 32'(e.alufun));
        chk("ex_sign", 32'(ex_sign), 32'(e.sign));
        chk("ex_store_data", ex_store_data, e.store);
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("ex_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
            {29'd0, e.rw, e.mr, e.mw});
      end
    end
  end

  initial begin
    in_t x, y, z;
    x = '0; x.reset = 1'b1;
    m_ex = '0;
    apply(x);
    sb.delete();
    step(x);
    step(x);

    // Mid-stream reset held for two cycles, then first load.
    for (int i = 0; i < 10; i++) begin
      x = rand_in(); x.reset = 1'b0; step(x);
    end
    x = '0; x.reset = 1'b1;
    step(x); step(x);
    y = '0; y.id_valid = 1'b1; y.pc = 32'h400; y.reg_write = 1'b1; y.rd = 5'd3;
    step(y);
    #2;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_A", ex_A, 32'd0);
    chk("rst_B", ex_B, 32'd0);
    step('0);
    #2;
    chk("post_rst_pc", ex_pc, 32'h400);
    chk("post_rst_valid", 32'(ex_valid), 32'd1);

    // EX/MEM wins over MEM/WB; register 0 never forwards.
    y = '0; y.id_valid = 1'b1; y.rs = 5'd5; y.rs_data = 32'hAAAA;
    step(y);
    z = '0; z.exmem_rw = 1'b1; z.exmem_rd = 5'd5; z.exmem_res = 32'h11;
    z.memwb_rw = 1'b1; z.memwb_rd = 5'd5; z.memwb_res = 32'h22;
    step(z);
    #2; chk("fwd_exmem_A", ex_A, 32'h11);
    y.rs = 5'd0; y.rs_data = 32'h33;
    step(y);
    z.exmem_rd = 5'd0; z.memwb_rd = 5'd0;
    step(z);
    #2; chk("fwd_r0_A", ex_A, 32'h33);

    // Load-use: lw $8 then add using rt=$8.
    x = '0; x.id_valid = 1'b1; x.mem_read = 1'b1; x.reg_write = 1'b1; x.rd = 5'd8; x.rs = 5'd2;
    step(x);
    y = '0; y.id_valid = 1'b1; y.rs = 5'd3; y.rt = 5'd8; y.rd = 5'd9; y.reg_write = 1'b1;
    y.rt_data = 32'h1111;
    step(y);
    #2; chk("lu_stall", 32'(stall_id), 32'd1);
    z = y; z.exmem_rw = 1'b1; z.exmem_rd = 5'd8; z.exmem_res = 32'h1000;
    step(z);
    #2; chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_stall_gone", 32'(stall_id), 32'd0);
    x = '0; x.memwb_rw = 1'b1; x.memwb_rd = 5'd8; x.memwb_res = 32'hBEEF;
    step(x);
    #2; chk("lu_fwd_B", ex_B, 32'hBEEF);

    // Flush kills the ID instruction.
    x = '0; x.id_valid = 1'b1; x.reg_write = 1'b1; x.mem_write = 1'b1; x.flush = 1'b1;
    step(x);
    step('0);
    #2; chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_ctrl", {30'd0, ex_reg_write, ex_mem_write}, 32'd0);

    // Hold for three cycles with a flush in the middle.
    x = '0; x.id_valid = 1'b1; x.pc = 32'hA0; x.reg_write = 1'b1;
    step(x);
    y = '0; y.id_valid = 1'b1; y.pc = 32'hB0; y.reg_write = 1'b1; y.hold = 1'b1;
    step(y);
    #2; chk("hold_pc1", ex_pc, 32'hA0);
    y.flush = 1'b1; step(y); y.flush = 1'b0;
    #2; chk("hold_pc2", ex_pc, 32'hA0);
    step(y);
    #2; chk("hold_pc3", ex_pc, 32'hA0);
    y.hold = 1'b0;
    step(y);
    step('0);
    #2; chk("hold_bubble", 32'(ex_valid), 32'd0);

    // Immediate/shamt sources with rt forwarded to store data.
    x = '0; x.id_valid = 1'b1; x.alusrc1 = 1'b1; x.shamt = 5'd7; x.alusrc2 = 1'b1;
    x.imm = 32'hFFFFFFFC; x.rt = 5'd4; x.rt_data = 32'h1234; x.mem_write = 1'b1;
    step(x);
    z = '0; z.exmem_rw = 1'b1; z.exmem_rd = 5'd4; z.exmem_res = 32'h5555;
    step(z);
    #2; chk("src_A", ex_A, 32'd7);
    chk("src_B", ex_B, 32'hFFFFFFFC);
    chk("src_store", ex_store_data, 32'h5555);

    for (int i = 0; i < 400; i++) step(rand_in());

    @(posedge clk);
    @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
